dual_ram_be: RTL and testbench

Byte-enabled simple dual-port RAM, the parametrised successor to the existing dual-port RAM used for register-file, data-memory and scratch storage in the core. It adds per-byte write enables and a byte-accurate read-during-write bypass. A hardware clear engine zeroes the array after reset or on request, and a read-valid strobe is provided. Writes and reads use one synchronous port each on a single clock.

---
 rtl/dual_ram_be.sv | 206 ++++++++++++++++++++
 tb/tb_dual_ram_be.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_ram_be.sv
// ---------------------------------------------------------------------------
// dual_ram_be
//
// Byte-enabled simple dual-port RAM with a hardware clear engine.
// One synchronous write port and one synchronous read port share a single
// clock. Each write byte has its own enable. A read and a write to the same
// address in the same cycle return the merged word, byte by byte.
// After reset, or on a clr_req pulse, the clear engine zeroes every word.
// While it runs, busy_o is high and all accesses are ignored.
//
// Optional feature macro:
//   DUAL_RAM_BE_OUTREG_EN - adds an output register stage after the bypass
//                           merge. Read latency becomes 2 cycles.
//
// Parameters:
//   DW       data width in bits (multiple of 8)
//   AW       address width
//   MEM_NUM  number of words (MEM_NUM <= 2**AW)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clr_req    pulse: zero the whole array (ignored while clearing)
//   busy_o     clear engine running
//   w_en       write request
//   w_be_i     byte write enables, bit k covers data bits [8k+7:8k]
//   w_addr_i   write address
//   w_data_i   write data
//   r_en       read request
//   r_addr_i   read address
//   r_data_o   read data
//   r_valid_o  r_data_o holds the result of an accepted read
// ---------------------------------------------------------------------------
module dual_ram_be #(
    parameter int DW      = 32,
    parameter int AW      = 12,
    parameter int MEM_NUM = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_req,
    output logic            busy_o,
    input  logic            w_en,
    input  logic [DW/8-1:0] w_be_i,
    input  logic [AW-1:0]   w_addr_i,
    input  logic [DW-1:0]   w_data_i,
    input  logic            r_en,
    input  logic [AW-1:0]   r_addr_i,
    output logic [DW-1:0]   r_data_o,
    output logic            r_valid_o
);

    localparam int NB = DW / 8;
    // Index width that exactly covers the array; addresses are range-checked
    // before being truncated to it.
    localparam int IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
    localparam logic [AW:0]   MEM_END   = (AW + 1)'(MEM_NUM);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_NUM - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;

    logic [DW-1:0] mem [0:MEM_NUM-1];

    logic          w_acc;
    logic          r_acc;
    logic          r_oob;

    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [NB-1:0] mem_be;
    logic [DW-1:0] mem_wd;

    logic [DW-1:0] rd_raw;
    logic          rd_valid;
    logic          byp_flag;
    logic [NB-1:0] byp_be;
    logic [DW-1:0] byp_data;
    logic [DW-1:0] rd_merged;

    assign busy_o = (state == CLEAR);
    assign w_acc  = w_en && !busy_o && ({1'b0, w_addr_i} < MEM_END);
    assign r_acc  = r_en && !busy_o;
    assign r_oob  = !({1'b0, r_addr_i} < MEM_END);

    // Clear engine. Reset always (re)starts a full clear from address 0;
    // clr_req is only honoured from IDLE so a clear can never be extended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // Single physical write port: the clear engine and user writes are
    // mutually exclusive because user writes are refused while busy.
    always_comb begin
        mem_we  = 1'b0;
        mem_idx = w_addr_i[IW-1:0];
        mem_be  = w_be_i;
        mem_wd  = w_data_i;
        if (busy_o) begin
            mem_we  = 1'b1;
            mem_idx = clr_cnt[IW-1:0];
            mem_be  = '1;
            mem_wd  = '0;
        end else if (w_acc) begin
            mem_we  = 1'b1;
        end
    end

    // The array itself has no reset; the clear engine zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (mem_be[k]) begin
                    mem[mem_idx][8*k +: 8] <= mem_wd[8*k +: 8];
                end
            end
        end
    end

    // Read stage. The array read returns pre-write content, so the write
    // enables and data are captured alongside it to merge the bypass bytes.
    // Everything holds when no read is accepted, so r_data_o keeps its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_raw   <= '0;
            rd_valid <= 1'b0;
            byp_flag <= 1'b0;
            byp_be   <= '0;
            byp_data <= '0;
        end else begin
            rd_valid <= r_acc;
            if (r_acc) begin
                rd_raw   <= r_oob ? '0 : mem[r_addr_i[IW-1:0]];
                byp_flag <= w_acc && (w_addr_i == r_addr_i);
                byp_be   <= w_be_i;
                byp_data <= w_data_i;
            end
        end
    end

    always_comb begin
        rd_merged = rd_raw;
        if (byp_flag) begin
            for (int k = 0; k < NB; k++) begin
                if (byp_be[k]) begin
                    rd_merged[8*k +: 8] = byp_data[8*k +: 8];
                end
            end
        end
    end

`ifdef DUAL_RAM_BE_OUTREG_EN
    logic [DW-1:0] out_data;
    logic          out_valid;

    // Extra output stage; data only advances on a valid read so the
    // hold-last-value behaviour is preserved at the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_valid;
            if (rd_valid) begin
                out_data <= rd_merged;
            end
        end
    end

    assign r_data_o  = out_data;
    assign r_valid_o = out_valid;
`else
    assign r_data_o  = rd_merged;
    assign r_valid_o = rd_valid;
`endif

endmodule

// File: tb/tb_dual_ram_be.sv
// ---------------------------------------------------------------------------
// tb_dual_ram_be
//
// Self-checking bench for dual_ram_be with a 16-word, 32-bit array and a
// 5-bit address so out-of-range addresses can be exercised. Handles both
// builds (DUAL_RAM_BE_OUTREG_EN adds one cycle of read latency).
// ---------------------------------------------------------------------------
module tb_dual_ram_be;

    localparam int DW      = 32;
    localparam int AW      = 5;
    localparam int MEM_NUM = 16;
`ifdef DUAL_RAM_BE_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          clr_req;
    logic          busy_o;
    logic          w_en;
    logic [3:0]    w_be_i;
    logic [AW-1:0] w_addr_i;
    logic [DW-1:0] w_data_i;
    logic          r_en;
    logic [AW-1:0] r_addr_i;
    logic [DW-1:0] r_data_o;
    logic          r_valid_o;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic          we;
        logic [3:0]    be;
        logic [AW-1:0] waddr;
        logic [31:0]   wdata;
        logic          re;
        logic [AW-1:0] raddr;
        logic          exp_valid;
        logic [31:0]   exp_data;
    } vec_t;

    vec_t vecs [16];

    dual_ram_be #(
        .DW      (DW),
        .AW      (AW),
        .MEM_NUM (MEM_NUM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .busy_o    (busy_o),
        .w_en      (w_en),
        .w_be_i    (w_be_i),
        .w_addr_i  (w_addr_i),
        .w_data_i  (w_data_i),
        .r_en      (r_en),
        .r_addr_i  (r_addr_i),
        .r_data_o  (r_data_o),
        .r_valid_o (r_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        clr_req  = 1'b0;
        w_en     = 1'b0;
        w_be_i   = 4'h0;
        w_addr_i = '0;
        w_data_i = '0;
        r_en     = 1'b0;
        r_addr_i = '0;
    endtask

    // Called at a falling edge: drives one transaction for one rising edge,
    // then idles until the read result is due at a falling edge.
    task automatic applyStimulus(input vec_t v);
        w_en     = v.we;
        w_be_i   = v.be;
        w_addr_i = v.waddr;
        w_data_i = v.wdata;
        r_en     = v.re;
        r_addr_i = v.raddr;
        @(posedge clk);
        @(negedge clk);
        idleInputs();
        repeat (LAT - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Counts rising edges until busy_o is seen low, bounded.
    task automatic waitBusyLow(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!busy_o) break;
        end
    endtask

    task automatic readWord(input logic [AW-1:0] addr, input logic [31:0] exp, input string name);
        vec_t v;
        v = '{1'b0, 4'h0, '0, 32'h0, 1'b1, addr, 1'b1, exp};
        applyStimulus(v);
        checkOutput({name, " valid"}, {31'b0, r_valid_o}, 32'd1);
        checkOutput({name, " data"}, r_data_o, exp);
    endtask

    initial begin
        int n;
        logic any_valid;
        logic [31:0] pipe_exp [3];

        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        idleInputs();

        vecs[0]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd3,  1'b1, 32'h00000000};
        vecs[1]  = '{1'b1, 4'hF, 5'd5,  32'hAABBCCDD, 1'b0, 5'd0,  1'b0, 32'h00000000};
        vecs[2]  = '{1'b1, 4'h5, 5'd5,  32'h11223344, 1'b0, 5'd0,  1'b0, 32'h00000000};
        vecs[3]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd5,  1'b1, 32'hAA22CC44};
        vecs[4]  = '{1'b1, 4'hF, 5'd9,  32'h01020304, 1'b0, 5'd0,  1'b0, 32'hAA22CC44};
        vecs[5]  = '{1'b1, 4'hC, 5'd9,  32'h55667788, 1'b1, 5'd9,  1'b1, 32'h55660304};
        vecs[6]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd9,  1'b1, 32'h55660304};
        vecs[7]  = '{1'b1, 4'hF, 5'd20, 32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 32'h55660304};
        vecs[8]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd20, 1'b1, 32'h00000000};
        vecs[9]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd4,  1'b1, 32'h00000000};
        vecs[10] = '{1'b1, 4'h0, 5'd1,  32'hFFFFFFFF, 1'b1, 5'd1,  1'b1, 32'h00000000};
        vecs[11] = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd1,  1'b1, 32'h00000000};
        vecs[12] = '{1'b1, 4'h1, 5'd1,  32'h000000A1, 1'b1, 5'd2,  1'b1, 32'h00000000};
        vecs[13] = '{1'b1, 4'hF, 5'd2,  32'h000000B2, 1'b0, 5'd0,  1'b0, 32'h00000000};
        vecs[14] = '{1'b1, 4'hF, 5'd3,  32'h000000C3, 1'b0, 5'd0,  1'b0, 32'h00000000};
        vecs[15] = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd1,  1'b1, 32'h000000A1};

        // Reset state
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", {31'b0, busy_o}, 32'd1);
        checkOutput("reset valid", {31'b0, r_valid_o}, 32'd0);
        checkOutput("reset data", r_data_o, 32'h0);
        rst = 1'b0;
        waitBusyLow(n);
        checkOutput("reset clear edges", n, MEM_NUM);

        // Table-driven single transactions
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].exp_valid)
                checkOutput($sformatf("vec%0d data", i), r_data_o, vecs[i].exp_data);
            else
                checkOutput($sformatf("vec%0d held data", i), r_data_o, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d valid", i), {31'b0, r_valid_o}, {31'b0, vecs[i].exp_valid});
        end

        // Back-to-back reads of addresses 1, 2, 3
        pipe_exp[0] = 32'h000000A1;
        pipe_exp[1] = 32'h000000B2;
        pipe_exp[2] = 32'h000000C3;
        r_en     = 1'b1;
        r_addr_i = 5'd1;
        for (int i = 0; i < LAT + 3; i++) begin
            int j;
            @(posedge clk);
            @(negedge clk);
            j = i - (LAT - 1);
            if (j >= 0 && j < 3) begin
                checkOutput($sformatf("pipe%0d valid", j), {31'b0, r_valid_o}, 32'd1);
                checkOutput($sformatf("pipe%0d data", j), r_data_o, pipe_exp[j]);
            end else if (j >= 3) begin
                checkOutput("pipe tail valid", {31'b0, r_valid_o}, 32'd0);
            end
            if (i < 2) begin
                r_addr_i = AW'(i + 2);
            end else begin
                r_en     = 1'b0;
                r_addr_i = '0;
            end
        end

        // Clear request with accesses attempted while busy
        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req = 1'b0;
        checkOutput("clr busy rise", {31'b0, busy_o}, 32'd1);
        r_en     = 1'b1;
        r_addr_i = 5'd1;
        w_en     = 1'b1;
        w_be_i   = 4'hF;
        w_addr_i = 5'd6;
        w_data_i = 32'hFFFFFFFF;
        any_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (r_valid_o) any_valid = 1'b1;
            clr_req = (n == 5);
            if (!busy_o) break;
        end
        idleInputs();
        checkOutput("valid while busy", {31'b0, any_valid}, 32'd0);
        checkOutput("clr busy edges", n, MEM_NUM);
        for (int a = 0; a < MEM_NUM; a++) begin
            readWord(AW'(a), 32'h0, $sformatf("cleared addr%0d", a));
        end

        // Reset in the middle of a clear restarts it
        applyStimulus('{1'b1, 4'hF, 5'd9, 32'h12345678, 1'b0, 5'd0, 1'b0, 32'h0});
        readWord(5'd9, 32'h12345678, "pre-clear addr9");
        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid-clear rst busy", {31'b0, busy_o}, 32'd1);
        checkOutput("mid-clear rst data", r_data_o, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitBusyLow(n);
        checkOutput("restart clear edges", n, MEM_NUM);
        readWord(5'd9, 32'h0, "restart addr9");
        applyStimulus('{1'b1, 4'hF, 5'd20, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 32'h0});
        readWord(5'd20, 32'h0, "oob addr20");
        readWord(5'd4, 32'h0, "alias addr4");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
